pio_out_pulse: RTL and testbench



---
 rtl/pio_out_pulse_if.sv | 25 ++
 rtl/pio_out_pulse.sv | 125 ++++++++++++
 tb/tb_pio_out_pulse.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pio_out_pulse_if.sv
// pio_out_pulse_if: Avalon-MM slave bus bundle for the output PIO.
// Carries the word address, select, write strobe and both data paths.
interface pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_out_pulse.sv
// pio_out_pulse: output PIO with DATA/SET/CLEAR and a one-shot PULSE reg.
// Pulse path, counter and STATUS.busy exist only with PIO_OUT_PULSE_EN.
module pio_out_pulse #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_out_pulse_if.slave   bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_SET    = 3'd2;
  localparam logic [2:0] A_CLEAR  = 3'd3;
  localparam logic [2:0] A_PULSE  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             sel_data;
  logic             sel_set;
  logic             sel_clr;
  logic             sel_pulse;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] pulse_bits;
  logic             busy;
  logic [31:0]      rd;
  logic             unused_wd;

  assign wr = bus.chipselect & ~bus.write_n;
  assign wd = bus.writedata[WIDTH-1:0];

  // Upper write-data bits are architecturally ignored.
  assign unused_wd = ^bus.writedata;

  // One-hot write decode of the register map.
  always_comb begin
    sel_data  = 1'b0;
    sel_set   = 1'b0;
    sel_clr   = 1'b0;
    sel_pulse = 1'b0;
    case (bus.address)
      A_DATA:  sel_data  = wr;
      A_SET:   sel_set   = wr;
      A_CLEAR: sel_clr   = wr;
      A_PULSE: sel_pulse = wr;
      default: ;
    endcase
  end

  // Data register: load, atomic set and atomic clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else begin
      unique case (1'b1)
        sel_data: data_reg <= wd;
        sel_set:  data_reg <= data_reg | wd;
        sel_clr:  data_reg <= data_reg & ~wd;
        default:  ;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pulse_mask;
  logic             expiring;
  logic             pulse_go;

  assign expiring = (count == ONE);
  assign pulse_go = sel_pulse & (wd != '0);
  assign busy     = (count != '0);

  // One-shot mask: OR in new bits, drop stale bits on the expiring
  // edge, and hold everything until PULSE_CYCLES after the last write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pulse_mask <= '0;
      count      <= '0;
    end else if (pulse_go) begin
      pulse_mask <= (expiring ? '0 : pulse_mask) | wd;
      count      <= LOAD;
    end else if (expiring) begin
      pulse_mask <= '0;
      count      <= '0;
    end else if (busy) begin
      count      <= count - ONE;
    end
  end

  assign pulse_bits = pulse_mask;

`else

  assign busy       = 1'b0;
  assign pulse_bits = '0;

`endif

  assign out_port = data_reg | pulse_bits;

  // Zero-wait read mux; unused bits and write-only regs read as 0.
  always_comb begin
    rd = '0;
    case (bus.address)
      A_DATA:   rd = 32'(data_reg);
      A_OUT:    rd = 32'(out_port);
      A_PULSE:  rd = 32'(pulse_bits);
      A_STATUS: rd = 32'(busy);
      default:  rd = '0;
    endcase
  end

  assign bus.readdata = rd;

endmodule

// File: tb/tb_pio_out_pulse.sv
// tb_pio_out_pulse: directed plus random bus traffic against a
// deadline-based reference model of the output PIO.
module tb_pio_out_pulse;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam int         PC = 4;
  localparam int         M  = 32'h0000_00FF;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;

  int n_tests = 0;
  int n_fail  = 0;

  bit en;
  int m_data;
  int m_mask;
  int m_exp;
  int edge_n;

  pio_out_pulse_if bus_if();

  pio_out_pulse #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_active();
    return edge_n < m_exp;
  endfunction

  function automatic logic [31:0] m_out();
    return 32'(m_data | (m_active() ? m_mask : 0));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return m_out();
      3'd4: return (en && m_active()) ? 32'(m_mask) : 32'h0;
      3'd5: return (en && m_active()) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc(input bit rst, input logic [2:0] a,
                     input bit cs, input bit wn,
                     input logic [31:0] wd);
    int v;
    @(negedge clk);
    reset_n            = !rst;
    bus_if.address     = a;
    bus_if.chipselect  = cs;
    bus_if.write_n     = wn;
    bus_if.writedata   = wd;
    #1;
    if (!rst && edge_n > 0)
      check($sformatf("rd@%0d", a), bus_if.readdata, m_read(a));
    @(posedge clk);
    edge_n++;
    v = int'(wd) & M;
    if (rst) begin
      m_data = int'(RV);
      m_mask = 0;
      m_exp  = 0;
    end else if (cs && !wn) begin
      case (a)
        3'd0: m_data = v;
        3'd2: m_data = m_data | v;
        3'd3: m_data = m_data & ~v & M;
        3'd4:
          if (en && v != 0) begin
            m_mask = (m_active() ? m_mask : 0) | v;
            m_exp  = edge_n + PC;
          end
        default: ;
      endcase
    end
    #1;
    check("out_port", 32'(out_port), m_out());
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(0, a, 1, 0, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(0, a, 1, 1, 32'h0);
  endtask

  initial begin
`ifdef PIO_OUT_PULSE_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    m_data = 0;
    m_mask = 0;
    m_exp  = 0;
    edge_n = 0;

    cyc(1, 3'd0, 0, 1, 32'h0);
    rd(3'd0);
    check("reset_out", 32'(out_port), 32'h0000_00A5);
    rd(3'd0);

    wr(3'd0, 32'hFFFF_FF3C);
    rd(3'd0);
    check("data_out", 32'(out_port), 32'h0000_003C);

    wr(3'd0, 32'h0F);
    wr(3'd2, 32'h30);
    rd(3'd1);
    check("set_out", 32'(out_port), 32'h0000_003F);
    wr(3'd3, 32'h05);
    rd(3'd2);
    rd(3'd3);
    check("clr_out", 32'(out_port), 32'h0000_003A);

    wr(3'd0, 32'h0);
    wr(3'd4, 32'h01);
    for (int i = 0; i < 6; i++) rd(3'd5);

    wr(3'd4, 32'h01);
    for (int i = 0; i < 3; i++) rd(3'd5);
    wr(3'd4, 32'h02);
    for (int i = 0; i < 5; i++) rd(3'd4);

    wr(3'd4, 32'h0C);
    rd(3'd5);
    wr(3'd4, 32'h00);
    for (int i = 0; i < 4; i++) rd(3'd5);

    wr(3'd0, 32'h81);
    wr(3'd4, 32'h81);
    for (int i = 0; i < 5; i++) rd(3'd1);

    wr(3'd4, 32'h40);
    rd(3'd5);
    cyc(1, 3'd5, 0, 1, 32'h0);
    rd(3'd5);
    check("rst_mid", 32'(out_port), 32'h0000_00A5);

    wr(3'd4, 32'hFF);
    rd(3'd4);
    rd(3'd5);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & 32'hFFFF_FF00;
      else if ($urandom_range(0, 1) == 0) d = d & 32'hFFFF_FF0F;
      cyc($urandom_range(0, 49) == 0,
          3'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0,
          d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
